// File: rtl/hazard_unit.sv
// Hazard and forwarding control for the 5-stage pipeline: scoreboard of in-flight
// destinations, stall/flush/enable generation, operand bypass selects and the HI/LO busy counter.
module hazard_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [1:0] tuseRsD,
  input  logic [1:0] tuseRtD,
  input  logic [4:0] a3D,
  input  logic [1:0] tnewD,
  input  logic [1:0] mdOpD,
  input  logic       mdUseD,
  output logic       enPC,
  output logic       enD,
  output logic       FlushE,
  output logic [1:0] fwdRsD,
  output logic [1:0] fwdRtD,
  output logic [1:0] fwdRsE,
  output logic [1:0] fwdRtE,
  output logic       mdBusy
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int MDW    = ($clog2(MD_MAX + 1) > 4) ? $clog2(MD_MAX + 1) : 4;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2
  } md_op_e;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
  } stage_t;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } e_stage_t;

  e_stage_t       e_q;
  stage_t         m_q, w_q;
  logic [MDW-1:0] md_cnt_q;
  logic           stall;

  function automatic logic hit(input logic [4:0] r, input logic [4:0] a3);
    return (r != 5'd0) && (r == a3);
  endfunction

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Only the newest matching producer (E before M) decides whether to wait.
  function automatic logic op_stall(input logic [4:0] r, input logic [1:0] tuse,
                                    input e_stage_t e, input stage_t m);
    if (tuse == 2'd3)    return 1'b0;
    if (hit(r, e.a3))    return e.tnew > tuse;
    if (hit(r, m.a3))    return m.tnew > tuse;
    return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_d(input logic [4:0] r, input e_stage_t e,
                                       input stage_t m, input stage_t w);
    if (hit(r, e.a3)) return (e.tnew == 2'd0) ? 2'd3 : 2'd0;
    if (hit(r, m.a3)) return (m.tnew == 2'd0) ? 2'd1 : 2'd0;
    if (hit(r, w.a3)) return (w.tnew == 2'd0) ? 2'd2 : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] r, input stage_t m, input stage_t w);
    if (hit(r, m.a3) && m.tnew == 2'd0) return 2'd1;
    if (hit(r, w.a3))                   return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    // NOTE: every output gets a default before any condition so no latch is inferred.
    stall  = 1'b0;
    mdBusy = (md_cnt_q != '0);
    if (op_stall(rsD, tuseRsD, e_q, m_q) || op_stall(rtD, tuseRtD, e_q, m_q))
      stall = 1'b1;
    if (mdUseD && mdBusy)
      stall = 1'b1;
    enPC   = !stall;
    enD    = !stall;
    FlushE = stall;
    fwdRsD = fwd_d(rsD, e_q, m_q, w_q);
    fwdRtD = fwd_d(rtD, e_q, m_q, w_q);
    fwdRsE = fwd_e(e_q.rs, m_q, w_q);
    fwdRtE = fwd_e(e_q.rt, m_q, w_q);
  end

  // NOTE: state registers use non-blocking assignments so every stage shifts from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      md_cnt_q <= '0;
    end else begin
      e_q <= stall ? '0 : e_stage_t'{a3: a3D, tnew: tnewD, rs: rsD, rt: rtD};
      m_q <= stage_t'{a3: e_q.a3, tnew: dec_sat(e_q.tnew)};
      w_q <= stage_t'{a3: m_q.a3, tnew: dec_sat(m_q.tnew)};
      // A mult/div held in D by a stall must not start the unit yet.
      if (!stall && md_op_e'(mdOpD) == MD_MULT)
        md_cnt_q <= MDW'(MULT_CYCLES);
      else if (!stall && md_op_e'(mdOpD) == MD_DIV)
        md_cnt_q <= MDW'(DIV_CYCLES);
      else if (md_cnt_q != '0)
        md_cnt_q <= md_cnt_q - 1'b1;
    end
  end

endmodule
